data_mem_arbiter: RTL and testbench
===================================

// Module: data_mem_arbiter
// PURPOSE
//  Shares the single data-memory port between two requesters: port 0 = CPU load/store
//  path (ALUResult/WriteData/MemWrite/funct3), port 1 = program/data loader or debug
//  master. Valid/ready request handshake, one transaction in flight, fixed-latency memory
//  sequenced by an FSM, one-cycle response pulse to the owning requester. Sits between
//  the execute stage / loader and the data memory; its CPU-side ready is the stall source.
// PARAMETERS
//  DATA_WIDTH   32  data and address width
//  MEM_LATENCY  1   cycles from mem_en to valid mem_rdata; legal range 1..15
// PORTS
//  clk          in   1   clock; all state updates on rising edge
//  rst          in   1   synchronous, active-high reset
//  req_valid    in   2   per-port request valid (bit 0 = CPU, bit 1 = loader)
//  req_ready    out  2   per-port accept; handshake when valid & ready
//  req_we       in   2   per-port write enable (1 = store)
//  req_addr     in   2x DATA_WIDTH  per-port byte address
//  req_wdata    in   2x DATA_WIDTH  per-port store data
//  req_funct3   in   2x 3  per-port access size/sign (RV32I funct3)
//  rsp_valid    out  2   per-port one-cycle response/ack pulse
//  rsp_rdata    out  DATA_WIDTH  load data, valid while any rsp_valid bit is high
//  mem_en       out  1   memory access strobe, one cycle per transaction
//  mem_we       out  1   memory write enable, qualified by mem_en
//  mem_addr     out  DATA_WIDTH  registered address
//  mem_wdata    out  DATA_WIDTH  registered store data
//  mem_funct3   out  3   registered funct3
//  mem_rdata    in   DATA_WIDTH  memory read data
//  busy         out  1   high in every state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE, req_ready=0 during rst, rsp_valid=0, rsp_rdata=0, mem_en=0,
//   mem_we=0, mem_addr/wdata/funct3=0, busy=0, last_grant=1 (port 0 wins first tie).
//  FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//   IDLE: req_ready combinational: only the arbitration winner sees ready=1, other 0.
//    On handshake capture we/addr/wdata/funct3 and owner id; go ISSUE. No valid: stay.
//   ISSUE (1 cycle): mem_en=1, mem_we=captured we; load cnt=MEM_LATENCY-1; go WAIT.
//   WAIT: decrement cnt; when cnt==0 capture mem_rdata (0 for writes) into rsp_rdata; go RESP.
//   RESP (1 cycle): rsp_valid[owner]=1, other bit 0; go IDLE.
//  Latency handshake(T) -> rsp_valid at T+MEM_LATENCY+2; next handshake earliest T+MEM_LATENCY+3.
//  req_ready=0 in ISSUE/WAIT/RESP; requesters hold valid and fields stable until accepted
//   and keep at most one request outstanding. Dropping valid before ready is legal (no effect).
//  mem_* outputs hold last values outside ISSUE; only mem_en/mem_we drop to 0.
//  Writes: rsp_valid pulse is the store ack; rsp_rdata=0.
//  Reset mid-transaction: transaction dropped, no rsp_valid, FSM to IDLE next cycle.
//  cnt is 4 bits; MEM_LATENCY outside 1..15 is a elaboration-time $error.
// CONFIGURATION
//  DATA_MEM_ARB_RR_EN defined: round-robin; on simultaneous valid, grant port != last_grant;
//   last_grant updates on every handshake. Single valid always granted.
//  Not defined: fixed priority, port 0 always wins; last_grant unused (port 1 can starve).
// STRUCTURE
//  Package mem_arb_pkg: arb_state_t enum {IDLE,ISSUE,WAIT,RESP}, FUNCT3_W=3,
//   NUM_PORTS=2, CNT_W=4.
//  Sub-module mem_arb_grant: combinational 2-port winner select + last_grant register
//   (RR/fixed chosen by DATA_MEM_ARB_RR_EN). FSM and datapath registers stay in top.
// TESTING
//  1. Single CPU load, addr=0x10, MEM_LATENCY=1, mem_rdata=0xDEADBEEF -> mem_en at T+1,
//     rsp_valid=2'b01 at T+3, rsp_rdata=0xDEADBEEF, busy high T+1..T+3.
//  2. Port 1 store addr=0x20 wdata=0x12345678 -> mem_en=1 mem_we=1 at T+1 with those
//     values; rsp_valid=2'b10 at T+3, rsp_rdata=0.
//  3. Both valid every cycle, RR_EN defined, 4 transactions -> grant order 0,1,0,1;
//     without RR_EN -> 0,0,0,0 and req_ready[1] never high.
//  4. MEM_LATENCY=4, CPU load -> rsp_valid at T+6; req_ready=2'b00 T+1..T+6; next
//     accept at T+7.
//  5. rst asserted during WAIT -> no rsp_valid, mem_en=0, state IDLE, next request
//     with both valid goes to port 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package mem_arb_pkg;

  localparam int unsigned FUNCT3_W  = 3;
  localparam int unsigned NUM_PORTS = 2;
  localparam int unsigned CNT_W     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // One-hot port vector for a port id
  function automatic logic [NUM_PORTS-1:0] port_onehot(input logic id);
    logic [NUM_PORTS-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Two-port winner select for the data-memory arbiter.
// DATA_MEM_ARB_RR_EN defined: round-robin on ties using a last-grant register.
// Not defined: fixed priority, port 0 always wins a tie.
module mem_arb_grant
  import mem_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] i_valid,
  input  logic                 i_accept,
  output logic                 o_winner_c,
  output logic [NUM_PORTS-1:0] o_grant_c
);

  logic w_winner;

`ifdef DATA_MEM_ARB_RR_EN
  logic r_last_grant;

  // Remember the last served port; reset value lets port 0 win the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
    end else if (i_accept) begin
      r_last_grant <= w_winner;
    end
  end

  // Tie goes to the port not served last; a lone requester always wins
  always_comb begin
    w_winner = ~i_valid[0];
    if (&i_valid) begin
      w_winner = ~r_last_grant;
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{clk, rst, i_accept};

  // Fixed priority: port 0 wins whenever it is valid
  always_comb begin
    w_winner = ~i_valid[0];
  end
`endif

  assign o_winner_c = w_winner;
  assign o_grant_c  = i_valid & port_onehot(w_winner);

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one fixed-latency data-memory port between the CPU (port 0) and a
// loader/debug master (port 1). One transaction in flight, sequenced by
// IDLE -> ISSUE -> WAIT -> RESP. Tie policy selected by DATA_MEM_ARB_RR_EN.
module data_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_PORTS-1:0]                 req_valid,
  output logic [NUM_PORTS-1:0]                 req_ready,
  input  logic [NUM_PORTS-1:0]                 req_we,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] req_addr,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_PORTS-1:0][FUNCT3_W-1:0]   req_funct3,
  output logic [NUM_PORTS-1:0]                 rsp_valid,
  output logic [DATA_WIDTH-1:0]                rsp_rdata,
  output logic                                 mem_en,
  output logic                                 mem_we,
  output logic [DATA_WIDTH-1:0]                mem_addr,
  output logic [DATA_WIDTH-1:0]                mem_wdata,
  output logic [FUNCT3_W-1:0]                  mem_funct3,
  input  logic [DATA_WIDTH-1:0]                mem_rdata,
  output logic                                 busy
);

  // Latency counter is CNT_W bits wide, so only 1..15 can be sequenced
  if (MEM_LATENCY == 0 || MEM_LATENCY > 15) begin : g_lat_chk
    $error("data_mem_arbiter: MEM_LATENCY must be in 1..15");
  end

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LATENCY - 1);

  arb_state_t                 r_state;
  logic                       r_owner;
  logic                       r_we;
  logic [CNT_W-1:0]           r_cnt;
  logic                       r_mem_en;
  logic                       r_mem_we;
  logic [DATA_WIDTH-1:0]      r_mem_addr;
  logic [DATA_WIDTH-1:0]      r_mem_wdata;
  logic [FUNCT3_W-1:0]        r_mem_funct3;
  logic [NUM_PORTS-1:0]       r_rsp_valid;
  logic [DATA_WIDTH-1:0]      r_rsp_rdata;
  logic                       r_busy;

  logic                       w_winner;
  logic [NUM_PORTS-1:0]       w_grant;
  logic [NUM_PORTS-1:0]       w_ready;
  logic                       w_accept;

  mem_arb_grant u_grant (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (req_valid),
    .i_accept   (w_accept),
    .o_winner_c (w_winner),
    .o_grant_c  (w_grant)
  );

  // Only the arbitration winner sees ready, and only while idle and out of reset
  assign w_ready  = (r_state == IDLE && !rst) ? w_grant : '0;
  assign w_accept = |w_ready;

  // Transaction sequencer with registered memory-side and response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_owner      <= 1'b0;
      r_we         <= 1'b0;
      r_cnt        <= '0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_funct3 <= '0;
      r_rsp_valid  <= '0;
      r_rsp_rdata  <= '0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_owner      <= w_winner;
            r_we         <= req_we[w_winner];
            r_mem_en     <= 1'b1;
            r_mem_we     <= req_we[w_winner];
            r_mem_addr   <= req_addr[w_winner];
            r_mem_wdata  <= req_wdata[w_winner];
            r_mem_funct3 <= req_funct3[w_winner];
            r_busy       <= 1'b1;
            r_state      <= ISSUE;
          end
        end
        ISSUE: begin
          // Strobes last one cycle; address/data/funct3 hold their values
          r_mem_en <= 1'b0;
          r_mem_we <= 1'b0;
          r_cnt    <= LAT_M1;
          r_state  <= WAIT;
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_rsp_rdata <= r_we ? '0 : mem_rdata;
            r_rsp_valid <= port_onehot(r_owner);
            r_state     <= RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        RESP: begin
          r_rsp_valid <= '0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = w_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_rdata  = r_rsp_rdata;
  assign mem_en     = r_mem_en;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_funct3 = r_mem_funct3;
  assign busy       = r_busy;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: vector table, directed corner
// sequences and a randomized run against a transaction-level model.
// Instance A uses MEM_LATENCY=1, instance B uses MEM_LATENCY=4.
module tb_data_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned DW    = 32;
  localparam int unsigned LAT_A = 1;
  localparam int unsigned LAT_B = 4;
  localparam logic [DW-1:0] GARB = 32'hBAD0_BAD0;
`ifdef DATA_MEM_ARB_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A signals
  logic                   rst;
  logic [1:0]             req_valid, req_ready, req_we, rsp_valid;
  logic [1:0][DW-1:0]     req_addr, req_wdata;
  logic [1:0][2:0]        req_funct3;
  logic [DW-1:0]          rsp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic                   mem_en, mem_we, busy;
  logic [2:0]             mem_funct3;

  // Instance B signals
  logic                   b_rst;
  logic [1:0]             b_req_valid, b_req_ready, b_req_we, b_rsp_valid;
  logic [1:0][DW-1:0]     b_req_addr, b_req_wdata;
  logic [1:0][2:0]        b_req_funct3;
  logic [DW-1:0]          b_rsp_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic                   b_mem_en, b_mem_we, b_busy;
  logic [2:0]             b_mem_funct3;

  data_mem_arbiter #(.DATA_WIDTH(DW), .MEM_LATENCY(LAT_A)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_funct3(req_funct3), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_funct3(mem_funct3), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  data_mem_arbiter #(.DATA_WIDTH(DW), .MEM_LATENCY(LAT_B)) dut_b (
    .clk(clk), .rst(b_rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_we(b_req_we), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .req_funct3(b_req_funct3), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_funct3(b_mem_funct3), .mem_rdata(b_mem_rdata),
    .busy(b_busy)
  );

  // Memory: data appears exactly LAT cycles after the mem_en cycle, garbage otherwise
  logic [DW-1:0] mem [16];
  logic [DW-1:0] pipe_a [LAT_A];
  logic [DW-1:0] pipe_b [LAT_B];
  assign mem_rdata   = pipe_a[LAT_A-1];
  assign b_mem_rdata = pipe_b[LAT_B-1];

  function automatic logic [DW-1:0] init_val(input int i);
    return DW'(32'h1000_0000 + i * 32'h0001_0101);
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) mem[i] <= (i == 4) ? 32'hDEAD_BEEF : init_val(i);
  end

  always @(posedge clk) begin
    pipe_a[0] <= mem_en ? mem[mem_addr[5:2]] : GARB;
    for (int i = 1; i < LAT_A; i++) pipe_a[i] <= pipe_a[i-1];
    if (mem_en && mem_we) mem[mem_addr[5:2]] <= mem_wdata;
    pipe_b[0] <= b_mem_en ? mem[b_mem_addr[5:2]] : GARB;
    for (int i = 1; i < LAT_B; i++) pipe_b[i] <= pipe_b[i-1];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          port;
    logic          we;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [2:0]    f3;
    logic [1:0]    exp_rsp;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs [6];

  task automatic reset_a();
    rst = 1'b1;
    req_valid = 2'b00;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One request on instance A, timing checked from handshake cycle T
  task automatic run_txn(input vec_t v, input int idx);
    logic [1:0] oh;
    int         waited;
    oh = v.port ? 2'b10 : 2'b01;
    waited = 0;
    req_valid           = oh;
    req_we[v.port]      = v.we;
    req_addr[v.port]    = v.addr;
    req_wdata[v.port]   = v.wdata;
    req_funct3[v.port]  = v.f3;
    @(negedge clk);
    while (req_ready != oh && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk($sformatf("v%0d_ready", idx), DW'(req_ready), DW'(oh));
    @(posedge clk);
    #1 req_valid = 2'b00;
    @(negedge clk);
    chk($sformatf("v%0d_mem_en", idx), DW'(mem_en), DW'(1'b1));
    chk($sformatf("v%0d_mem_we", idx), DW'(mem_we), DW'(v.we));
    chk($sformatf("v%0d_mem_addr", idx), mem_addr, v.addr);
    chk($sformatf("v%0d_mem_wdata", idx), mem_wdata, v.wdata);
    chk($sformatf("v%0d_mem_f3", idx), DW'(mem_funct3), DW'(v.f3));
    chk($sformatf("v%0d_busy1", idx), DW'(busy), DW'(1'b1));
    for (int k = 2; k <= LAT_A + 2; k++) begin
      @(negedge clk);
      chk($sformatf("v%0d_busy%0d", idx, k), DW'(busy), DW'(1'b1));
      chk($sformatf("v%0d_en_low%0d", idx, k), DW'(mem_en), DW'(1'b0));
      if (k < LAT_A + 2) begin
        chk($sformatf("v%0d_rsp_early%0d", idx, k), DW'(rsp_valid), DW'(2'b00));
      end else begin
        chk($sformatf("v%0d_rsp_valid", idx), DW'(rsp_valid), DW'(v.exp_rsp));
        chk($sformatf("v%0d_rsp_rdata", idx), rsp_rdata, v.exp_rdata);
      end
    end
    @(negedge clk);
    chk($sformatf("v%0d_rsp_done", idx), DW'(rsp_valid), DW'(2'b00));
    chk($sformatf("v%0d_idle", idx), DW'(busy), DW'(1'b0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         w;
    int         got [$];
    logic       saw1;
    logic [DW-1:0] ref_mem [16];

    // Reset state, with both requesters valid so ready=0 is meaningful
    rst = 1'b1; b_rst = 1'b1;
    req_valid = 2'b11; req_we = 2'b11;
    req_addr = '0; req_wdata = '0; req_funct3 = '0;
    req_addr[0] = 32'h10; req_wdata[0] = 32'h55; req_funct3[0] = 3'd2;
    b_req_valid = 2'b00; b_req_we = 2'b00;
    b_req_addr = '0; b_req_wdata = '0; b_req_funct3 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", DW'(req_ready), DW'(2'b00));
    chk("rst_rsp_valid", DW'(rsp_valid), DW'(2'b00));
    chk("rst_rsp_rdata", rsp_rdata, '0);
    chk("rst_mem_en", DW'(mem_en), DW'(1'b0));
    chk("rst_mem_we", DW'(mem_we), DW'(1'b0));
    chk("rst_mem_addr", mem_addr, '0);
    chk("rst_mem_wdata", mem_wdata, '0);
    chk("rst_mem_f3", DW'(mem_funct3), DW'(3'd0));
    chk("rst_busy", DW'(busy), DW'(1'b0));
    @(posedge clk);
    #1 rst = 1'b0; b_rst = 1'b0; req_valid = 2'b00; req_we = 2'b00;

    // Vector table: single-port transactions with known results
    vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0,         3'd2, 2'b01, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 1'b1, 32'h20, 32'h1234_5678, 3'd2, 2'b10, 32'h0};
    vecs[2] = '{1'b0, 1'b0, 32'h20, 32'h0,         3'd2, 2'b01, 32'h1234_5678};
    vecs[3] = '{1'b1, 1'b0, 32'h10, 32'h0,         3'd4, 2'b10, 32'hDEAD_BEEF};
    vecs[4] = '{1'b0, 1'b1, 32'h3C, 32'hA5A5_5A5A, 3'd0, 2'b01, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 32'h3C, 32'h0,         3'd5, 2'b10, 32'hA5A5_5A5A};
    for (int i = 0; i < 6; i++) run_txn(vecs[i], i);

    // Both ports valid every cycle: grant order over four transactions
    reset_a();
    req_we = 2'b00;
    req_addr[0] = 32'h04; req_addr[1] = 32'h08;
    req_valid = 2'b11;
    saw1 = 1'b0;
    w = 0;
    while (got.size() < 4 && w < 60) begin
      @(negedge clk);
      w++;
      if (req_ready[1]) saw1 = 1'b1;
      if (req_ready != 2'b00) got.push_back(req_ready[1] ? 1 : 0);
    end
    @(posedge clk);
    #1 req_valid = 2'b00;
    chk("tie_count", DW'(got.size()), DW'(4));
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      chk($sformatf("tie_grant%0d", i), DW'(got[i]), DW'(RR_MODE ? (i % 2) : 0));
    end
    chk("tie_p1_ready_seen", DW'(saw1), DW'(RR_MODE));
    repeat (6) @(posedge clk);
    #1;

    // Reset during WAIT drops the transaction and restores port-0 tie priority
    req_valid = 2'b01; req_addr[0] = 32'h10; req_we = 2'b00;
    w = 0;
    @(negedge clk);
    while (req_ready != 2'b01 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("rstw_accept", DW'(req_ready), DW'(2'b01));
    @(posedge clk);
    #1 req_valid = 2'b00;
    @(posedge clk);
    #1 rst = 1'b1;
    req_addr[0] = 32'h04; req_addr[1] = 32'h08; req_valid = 2'b11;
    @(negedge clk);
    chk("rstw_ready_in_rst", DW'(req_ready), DW'(2'b00));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rstw_no_rsp", DW'(rsp_valid), DW'(2'b00));
    chk("rstw_mem_en", DW'(mem_en), DW'(1'b0));
    chk("rstw_busy", DW'(busy), DW'(1'b0));
    chk("rstw_port0_wins", DW'(req_ready), DW'(2'b01));
    @(posedge clk);
    #1 req_valid = 2'b00;
    @(negedge clk);
    chk("rstw_next_addr", mem_addr, 32'h04);
    @(negedge clk);
    chk("rstw_next_rsp_early", DW'(rsp_valid), DW'(2'b00));
    @(negedge clk);
    chk("rstw_next_rsp", DW'(rsp_valid), DW'(2'b01));
    chk("rstw_next_rdata", rsp_rdata, init_val(1));
    @(posedge clk);
    #1;

    // MEM_LATENCY=4 on instance B: response at T+6, next accept at T+7
    b_req_valid = 2'b01; b_req_addr[0] = 32'h10; b_req_we = 2'b00; b_req_funct3[0] = 3'd2;
    w = 0;
    @(negedge clk);
    while (b_req_ready != 2'b01 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("lat4_accept", DW'(b_req_ready), DW'(2'b01));
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k <= 6) chk($sformatf("lat4_ready_low%0d", k), DW'(b_req_ready), DW'(2'b00));
      if (k == 1) chk("lat4_mem_en", DW'(b_mem_en), DW'(1'b1));
      if (k <= 5) chk($sformatf("lat4_rsp_early%0d", k), DW'(b_rsp_valid), DW'(2'b00));
      if (k <= 6) chk($sformatf("lat4_busy%0d", k), DW'(b_busy), DW'(1'b1));
      if (k == 6) begin
        chk("lat4_rsp_valid", DW'(b_rsp_valid), DW'(2'b01));
        chk("lat4_rsp_rdata", b_rsp_rdata, 32'hDEAD_BEEF);
      end
      if (k == 7) chk("lat4_next_accept", DW'(b_req_ready), DW'(2'b01));
    end
    b_req_valid = 2'b00;
    @(posedge clk);
    #1;

    // Randomized traffic on instance A against a transaction-level model
    reset_a();
    for (int i = 0; i < 16; i++) ref_mem[i] = mem[i];
    begin
      logic [1:0]    pend, exp_ready;
      logic          win, own, last, hs_we;
      logic [DW-1:0] hs_addr, hs_wdata, exp_rd;
      logic [2:0]    hs_f3;
      int            hs, free_at;
      pend = 2'b00; last = 1'b1; own = 1'b0; hs = -100; free_at = 0;
      hs_we = 1'b0; hs_addr = '0; hs_wdata = '0; hs_f3 = '0; exp_rd = '0;
      for (int n = 0; n < 600; n++) begin
        for (int p = 0; p < 2; p++) begin
          if (!pend[p]) begin
            if ($urandom_range(0, 2) == 0) begin
              pend[p]       = 1'b1;
              req_we[p]     = 1'($urandom_range(0, 1));
              req_addr[p]   = DW'($urandom_range(0, 15) * 4);
              req_wdata[p]  = DW'($urandom);
              req_funct3[p] = 3'($urandom_range(0, 7));
            end
          end else if ($urandom_range(0, 9) == 0) begin
            pend[p] = 1'b0;
          end
        end
        req_valid = pend;
        @(negedge clk);
        exp_ready = 2'b00;
        win = 1'b0;
        if (n >= free_at && pend != 2'b00) begin
          if (pend == 2'b11) win = RR_MODE ? ~last : 1'b0;
          else               win = pend[1];
          exp_ready = win ? 2'b10 : 2'b01;
        end
        chk($sformatf("rnd%0d_ready", n), DW'(req_ready), DW'(exp_ready));
        chk($sformatf("rnd%0d_mem_en", n), DW'(mem_en), DW'(n == hs + 1));
        chk($sformatf("rnd%0d_busy", n), DW'(busy), DW'(n > hs && n <= hs + int'(LAT_A) + 2));
        chk($sformatf("rnd%0d_rsp_valid", n), DW'(rsp_valid),
            DW'((n == hs + int'(LAT_A) + 2) ? (own ? 2'b10 : 2'b01) : 2'b00));
        if (n == hs + 1) begin
          chk($sformatf("rnd%0d_mem_we", n), DW'(mem_we), DW'(hs_we));
          chk($sformatf("rnd%0d_mem_addr", n), mem_addr, hs_addr);
          chk($sformatf("rnd%0d_mem_wdata", n), mem_wdata, hs_wdata);
          chk($sformatf("rnd%0d_mem_f3", n), DW'(mem_funct3), DW'(hs_f3));
        end
        if (n == hs + int'(LAT_A) + 2) begin
          chk($sformatf("rnd%0d_rdata", n), rsp_rdata, exp_rd);
        end
        if (exp_ready != 2'b00) begin
          hs       = n;
          own      = win;
          hs_we    = req_we[win];
          hs_addr  = req_addr[win];
          hs_wdata = req_wdata[win];
          hs_f3    = req_funct3[win];
          free_at  = n + int'(LAT_A) + 3;
          if (hs_we) begin
            ref_mem[hs_addr[5:2]] = hs_wdata;
            exp_rd = '0;
          end else begin
            exp_rd = ref_mem[hs_addr[5:2]];
          end
          last      = win;
          pend[win] = 1'b0;
        end
        @(posedge clk);
        #1;
      end
      req_valid = 2'b00;
    end
    repeat (8) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
